// File: rtl/img_window_ctrl.sv
// rtl/img_window_ctrl.sv - ROM-loaded image buffer with 2x2 window commands and RAM dump.
// Optional IMG_WINDOW_CTRL_RELOAD_EN makes command C reload the buffer from ROM.
module img_window_ctrl #(
  parameter int XW    = 3,
  parameter int YW    = 3,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         cmd,
  input  logic               cmd_valid,
  output logic               busy,
  output logic               rom_rd,
  output logic [XW+YW-1:0]   rom_a,
  input  logic [PIX_W-1:0]   rom_q,
  output logic               ram_valid,
  output logic [XW+YW-1:0]   ram_a,
  output logic [PIX_W-1:0]   ram_d,
  output logic               done
);
  localparam int AW = XW + YW;
  localparam int N  = 1 << AW;
  localparam logic [AW:0] LOAD_END = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] WR_LAST  = {1'b0, {AW{1'b1}}};

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_FIN} state_t;
  state_t state, state_nxt;

  logic [AW:0]        cnt;
  logic [3:0]         op;
  logic [XW-1:0]      ox, oxm;
  logic [YW-1:0]      oy, oym;
  logic               rd_d;
  logic [AW-1:0]      a_d;
  logic [PIX_W-1:0]   pix_buf [N];
  logic               is_reload;
  logic [AW-1:0]      i0, i1, i2, i3;
  logic [PIX_W-1:0]   p0, p1, p2, p3, n0, n1, n2, n3;
  logic [PIX_W-1:0]   m01, m23, mx, l01, l23, mn;
  logic [PIX_W+1:0]   sum;
  logic               win_we;

`ifdef IMG_WINDOW_CTRL_RELOAD_EN
  assign is_reload = (cmd == 4'hC);
`else
  assign is_reload = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    ram_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_LOAD:  if (cnt == LOAD_END && !rom_rd) state_nxt = S_IDLE;
      S_IDLE: begin
        busy = 1'b0;
        if (cmd_valid) begin
          if (cmd == 4'h0)    state_nxt = S_WRITE;
          else if (is_reload) state_nxt = S_LOAD;
          else                state_nxt = S_EXEC;
        end
      end
      S_EXEC:  state_nxt = S_IDLE;
      S_WRITE: begin
        ram_valid = 1'b1;
        if (cnt == WR_LAST) state_nxt = S_FIN;
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ram_a = ram_valid ? cnt[AW-1:0] : '0;
  assign ram_d = ram_valid ? pix_buf[cnt[AW-1:0]] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_LOAD;
      cnt    <= '0;
      rom_rd <= 1'b0;
      rom_a  <= '0;
      rd_d   <= 1'b0;
      a_d    <= '0;
      op     <= '0;
      ox     <= {1'b1, {(XW-1){1'b0}}};
      oy     <= {1'b1, {(YW-1){1'b0}}};
    end else begin
      state <= state_nxt;
      rd_d  <= rom_rd;
      a_d   <= rom_a;
      case (state)
        S_LOAD: begin
          if (cnt != LOAD_END) begin
            rom_rd <= 1'b1;
            rom_a  <= cnt[AW-1:0];
            cnt    <= cnt + (AW+1)'(1);
          end else begin
            rom_rd <= 1'b0;
          end
        end
        S_IDLE: begin
          if (cmd_valid) begin
            op <= cmd;
            // A reload starts reading immediately so it costs N+1 busy cycles.
            if (is_reload) begin
              rom_rd <= 1'b1;
              rom_a  <= '0;
              cnt    <= (AW+1)'(1);
            end else begin
              cnt <= '0;
            end
          end
        end
        S_WRITE: cnt <= cnt + (AW+1)'(1);
        S_EXEC: begin
          case (op)
            4'd1: if (oy != YW'(1))      oy <= oy - YW'(1);
            4'd2: if (oy != {YW{1'b1}})  oy <= oy + YW'(1);
            4'd3: if (ox != XW'(1))      ox <= ox - XW'(1);
            4'd4: if (ox != {XW{1'b1}})  ox <= ox + XW'(1);
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign oxm = ox - XW'(1);
  assign oym = oy - YW'(1);
  assign i0  = {oym, oxm};
  assign i1  = {oym, ox};
  assign i2  = {oy, oxm};
  assign i3  = {oy, ox};
  assign p0  = pix_buf[i0];
  assign p1  = pix_buf[i1];
  assign p2  = pix_buf[i2];
  assign p3  = pix_buf[i3];
  assign m01 = (p0 > p1) ? p0 : p1;
  assign m23 = (p2 > p3) ? p2 : p3;
  assign mx  = (m01 > m23) ? m01 : m23;
  assign l01 = (p0 < p1) ? p0 : p1;
  assign l23 = (p2 < p3) ? p2 : p3;
  assign mn  = (l01 < l23) ? l01 : l23;
  assign sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};

  always_comb begin
    n0     = p0;
    n1     = p1;
    n2     = p2;
    n3     = p3;
    win_we = 1'b1;
    case (op)
      4'd5:  begin n0 = mx; n1 = mx; n2 = mx; n3 = mx; end
      4'd6:  begin n0 = mn; n1 = mn; n2 = mn; n3 = mn; end
      4'd7:  begin
        n0 = sum[PIX_W+1:2]; n1 = sum[PIX_W+1:2];
        n2 = sum[PIX_W+1:2]; n3 = sum[PIX_W+1:2];
      end
      4'd8:  begin n0 = p1; n1 = p3; n3 = p2; n2 = p0; end
      4'd9:  begin n0 = p2; n2 = p3; n3 = p1; n1 = p0; end
      4'd10: begin n0 = p2; n2 = p0; n1 = p3; n3 = p1; end
      4'd11: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
      default: win_we = 1'b0;
    endcase
  end

  // ROM data lands one cycle after its address, tracked by rd_d/a_d.
  always_ff @(posedge clk) begin
    if (rd_d) begin
      pix_buf[a_d] <= rom_q;
    end else if (state == S_EXEC && win_we) begin
      pix_buf[i0] <= n0;
      pix_buf[i1] <= n1;
      pix_buf[i2] <= n2;
      pix_buf[i3] <= n3;
    end
  end
endmodule

// File: tb/tb_img_window_ctrl.sv
// tb/tb_img_window_ctrl.sv - randomized self-checking bench with an image-level reference model.
module tb_img_window_ctrl;
  localparam int XW = 3, YW = 3, PW = 8;
  localparam int W = 1 << XW, H = 1 << YW, N = W * H;

  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] cmd = 4'h0;
  logic cmd_valid = 1'b0;
  logic busy, rom_rd, ram_valid, done;
  logic [XW+YW-1:0] rom_a, ram_a;
  logic [PW-1:0] rom_q = '0, ram_d;

  int checks = 0, errors = 0;
  int rom_mem[N], img[N], cap[N];
  int ox, oy;
  int nbusy, nwr, ndone, nrd, seq_bad;

  always #5 clk = ~clk;
  always @(posedge clk) if (rom_rd) rom_q <= PW'(rom_mem[rom_a]);

  img_window_ctrl #(.XW(XW), .YW(YW), .PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .rom_rd(rom_rd), .rom_a(rom_a), .rom_q(rom_q), .ram_valid(ram_valid),
    .ram_a(ram_a), .ram_d(ram_d), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic watch(input bit hold);
    nbusy = 0; nwr = 0; ndone = 0; nrd = 0; seq_bad = 0;
    while (busy && nbusy < 5000) begin
      if (rom_rd) begin
        if (int'(rom_a) != nrd) seq_bad++;
        nrd++;
      end
      if (ram_valid) begin
        if (int'(ram_a) != nwr) seq_bad++;
        if (nwr < N) cap[nwr] = int'(ram_d);
        nwr++;
      end
      if (done) ndone++;
      if (hold) begin cmd = 4'h4; cmd_valid = 1'b1; end
      nbusy++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (nbusy >= 5000) check("timeout", nbusy, 0);
  endtask

  task automatic model(input logic [3:0] c);
    int i0, i1, i2, i3, p0, p1, p2, p3, r;
    i0 = (oy - 1) * W + (ox - 1); i1 = i0 + 1; i2 = i0 + W; i3 = i2 + 1;
    p0 = img[i0]; p1 = img[i1]; p2 = img[i2]; p3 = img[i3];
    case (c)
      4'd1: if (oy > 1) oy--;
      4'd2: if (oy < H - 1) oy++;
      4'd3: if (ox > 1) ox--;
      4'd4: if (ox < W - 1) ox++;
      4'd5: begin
        r = p0; if (p1 > r) r = p1; if (p2 > r) r = p2; if (p3 > r) r = p3;
        img[i0] = r; img[i1] = r; img[i2] = r; img[i3] = r;
      end
      4'd6: begin
        r = p0; if (p1 < r) r = p1; if (p2 < r) r = p2; if (p3 < r) r = p3;
        img[i0] = r; img[i1] = r; img[i2] = r; img[i3] = r;
      end
      4'd7: begin
        r = (p0 + p1 + p2 + p3) / 4;
        img[i0] = r; img[i1] = r; img[i2] = r; img[i3] = r;
      end
      4'd8:  begin img[i0] = p1; img[i1] = p3; img[i3] = p2; img[i2] = p0; end
      4'd9:  begin img[i0] = p2; img[i2] = p3; img[i3] = p1; img[i1] = p0; end
      4'd10: begin img[i0] = p2; img[i2] = p0; img[i1] = p3; img[i3] = p1; end
      4'd11: begin img[i0] = p1; img[i1] = p0; img[i2] = p3; img[i3] = p2; end
`ifdef IMG_WINDOW_CTRL_RELOAD_EN
      4'd12: for (int k = 0; k < N; k++) img[k] = rom_mem[k];
`endif
      default: ;
    endcase
  endtask

  task automatic issue(input logic [3:0] c, input bit hold);
    int exp_busy, exp_rd, guard;
    guard = 0;
    while (busy && guard < 5000) begin @(negedge clk); guard++; end
    cmd = c; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    watch(hold);
    exp_busy = (c == 4'h0) ? N + 1 : 1;
    exp_rd = 0;
`ifdef IMG_WINDOW_CTRL_RELOAD_EN
    if (c == 4'hC) begin exp_busy = N + 1; exp_rd = N; end
`endif
    check($sformatf("busy_c%0d", c), nbusy, exp_busy);
    check($sformatf("rom_rd_c%0d", c), nrd, exp_rd);
    model(c);
    if (c == 4'h0) begin
      check("wr_count", nwr, N);
      check("wr_done", ndone, 1);
      check("wr_seq", seq_bad, 0);
      for (int k = 0; k < N; k++) check($sformatf("pix%0d", k), cap[k], img[k]);
    end else begin
      check($sformatf("quiet_c%0d", c), nwr + ndone, 0);
    end
  endtask

  task automatic do_reset(input bit chk_vals);
    reset = 1'b1; cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    if (chk_vals) begin
      check("rst_busy", busy, 1);
      check("rst_rom_rd", rom_rd, 0);
      check("rst_rom_a", rom_a, 0);
      check("rst_ram_valid", ram_valid, 0);
      check("rst_ram_a", ram_a, 0);
      check("rst_ram_d", ram_d, 0);
      check("rst_done", done, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    watch(1'b0);
    check("load_rd", nrd, N);
    check("load_seq", seq_bad, 0);
    check("load_done", ndone, 0);
    for (int k = 0; k < N; k++) img[k] = rom_mem[k];
    ox = W / 2; oy = H / 2;
  endtask

  task automatic set_win(input int a, input int b, input int c, input int d);
    for (int k = 0; k < N; k++) rom_mem[k] = k;
    rom_mem[27] = a; rom_mem[28] = b; rom_mem[35] = c; rom_mem[36] = d;
  endtask

  task automatic check_win(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_p0"}, cap[27], a);
    check({tag, "_p1"}, cap[28], b);
    check({tag, "_p2"}, cap[35], c);
    check({tag, "_p3"}, cap[36], d);
  endtask

  initial begin
    int guard;
    logic [3:0] c;

    for (int k = 0; k < N; k++) rom_mem[k] = k;
    do_reset(1'b1);
    issue(4'h0, 1'b0);

    for (int i = 0; i < 5; i++) issue(4'h3, 1'b0);
    issue(4'h5, 1'b0);
    issue(4'h0, 1'b0);
    for (int i = 0; i < 8; i++) issue(4'h4, 1'b0);
    issue(4'h6, 1'b0);
    issue(4'h0, 1'b0);

    set_win(10, 200, 30, 41);
    do_reset(1'b0); issue(4'h5, 1'b0); issue(4'h0, 1'b0); check_win("max", 200, 200, 200, 200);
    do_reset(1'b0); issue(4'h7, 1'b0); issue(4'h0, 1'b0); check_win("avg", 70, 70, 70, 70);
    do_reset(1'b0); issue(4'h6, 1'b0); issue(4'h0, 1'b0); check_win("min", 10, 10, 10, 10);

    set_win(1, 2, 3, 4);
    do_reset(1'b0);
    issue(4'h9, 1'b0);  issue(4'h0, 1'b0); check_win("cw", 3, 1, 4, 2);
    issue(4'h8, 1'b0);  issue(4'h0, 1'b0); check_win("ccw", 1, 2, 3, 4);
    issue(4'hA, 1'b0);  issue(4'h0, 1'b0); check_win("mirx", 3, 4, 1, 2);
    issue(4'hA, 1'b0);
    issue(4'hB, 1'b0);  issue(4'h0, 1'b0); check_win("miry", 2, 1, 4, 3);

    issue(4'h0, 1'b1);
    issue(4'h1, 1'b1);
    issue(4'h5, 1'b0);
    issue(4'h0, 1'b0);

    guard = 0;
    while (busy && guard < 5000) begin @(negedge clk); guard++; end
    cmd = 4'h0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(ram_valid && ram_a == 20) && guard < 200) begin @(negedge clk); guard++; end
    check("midwr_reached", ram_a, 20);
    reset = 1'b1;
    #1;
    check("midwr_ram_valid", ram_valid, 0);
    check("midwr_rom_a", rom_a, 0);
    check("midwr_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    watch(1'b0);
    check("midwr_reload", nrd, N);
    check("midwr_done", ndone, 0);
    check("midwr_wr", nwr, 0);
    for (int k = 0; k < N; k++) img[k] = rom_mem[k];
    ox = W / 2; oy = H / 2;
    issue(4'h0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) rom_mem[k] = int'($urandom_range(0, (1 << PW) - 1));
      do_reset(1'b0);
      for (int i = 0; i < 60; i++) begin
        c = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 13));
        if (c == 4'hC)
          for (int k = 0; k < N; k++) rom_mem[k] = int'($urandom_range(0, (1 << PW) - 1));
        issue(c, 1'($urandom_range(0, 1)));
      end
      issue(4'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
